// File: rtl/fifo_wr_burst_ctrl.sv
// Write-side feeder for the async FIFO: 2-entry skid buffer, bounded bursts
// throttled by full/half_full, forced idle gap between bursts, statistics.
module fifo_wr_burst_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 64,
   parameter int BURST_LEN  = 8,
   parameter int GAP_CYCLES = 2,
   parameter int CNT_W      = 16
) (
   input  logic                  wr_clk,
   input  logic                  wr_rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   input  logic                  burst_abort,
   input  logic                  full,
   input  logic                  half_full,
   output logic                  wr_en,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  burst_active,
   output logic [CNT_W-1:0]      words_written,
   output logic [CNT_W-1:0]      bursts_done
);

   localparam int BEAT_W = $clog2(BURST_LEN + 1);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(GAP_CYCLES - 1);

   if (BURST_LEN < 1 || BURST_LEN > DEPTH / 2 || GAP_CYCLES < 1) begin : g_param_check
      $error("fifo_wr_burst_ctrl: illegal BURST_LEN/GAP_CYCLES for this DEPTH");
   end

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_e;

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   skid_q [2];
   logic [DATA_WIDTH-1:0]   skid_d [2];
   logic [1:0]              cnt_q, cnt_d;
   logic                    ready_q;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic [GAP_W-1:0]        gap_q, gap_d;
   logic [CNT_W-1:0]        words_q, words_d;
   logic [CNT_W-1:0]        bursts_q, bursts_d;
   logic [DATA_WIDTH-1:0]   last_q;
   logic                    write;
   logic                    push;
   logic                    push_idx;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d  = state_q;
      beat_d   = beat_q;
      gap_d    = gap_q;
      words_d  = words_q;
      bursts_d = bursts_q;
      write    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cnt_q != 2'd0 && !half_full) begin
               state_d = S_BURST;
               beat_d  = '0;
            end
         end
         S_BURST: begin
            if (burst_abort) begin
               state_d  = S_GAP;
               gap_d    = '0;
               bursts_d = bursts_q + 1'b1;
            end else if (cnt_q != 2'd0 && !full) begin
               write   = 1'b1;
               beat_d  = beat_q + 1'b1;
               words_d = words_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  state_d  = S_GAP;
                  gap_d    = '0;
                  bursts_d = bursts_q + 1'b1;
               end
            end
         end
         S_GAP: begin
            if (gap_q == LAST_GAP) state_d = S_IDLE;
            else                   gap_d   = gap_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Skid queue: head always sits in slot 0; a pop shifts slot 1 down.
   always_comb begin
      push     = in_valid && ready_q;
      push_idx = write ? (cnt_q == 2'd2) : (cnt_q == 2'd1);
      skid_d   = skid_q;
      cnt_d    = cnt_q;
      if (write) begin
         skid_d[0] = skid_q[1];
         cnt_d     = cnt_q - 2'd1;
      end
      if (push) begin
         skid_d[push_idx] = in_data;
         cnt_d            = cnt_d + 2'd1;
      end
   end

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         state_q   <= S_IDLE;
         // NOTE: the two skid slots are cleared too, so no stale word can surface after reset.
         skid_q[0] <= '0;
         skid_q[1] <= '0;
         cnt_q     <= '0;
         ready_q   <= 1'b0;
         beat_q    <= '0;
         gap_q     <= '0;
         words_q   <= '0;
         bursts_q  <= '0;
         last_q    <= '0;
      end else begin
         state_q  <= state_d;
         skid_q   <= skid_d;
         cnt_q    <= cnt_d;
         ready_q  <= (cnt_d != 2'd2);
         beat_q   <= beat_d;
         gap_q    <= gap_d;
         words_q  <= words_d;
         bursts_q <= bursts_d;
         last_q   <= wr_data;
      end
   end

   assign wr_en         = write;
   assign wr_data       = write ? skid_q[0] : last_q;
   assign in_ready      = ready_q;
   assign burst_active  = (state_q == S_BURST);
   assign words_written = words_q;
   assign bursts_done   = bursts_q;

endmodule

// File: doc/fifo_wr_burst_ctrl.md
Name: fifo_wr_burst_ctrl

Overview:
Write-side feeder stage that sits directly upstream of the async FIFO write port, in the write clock domain.
- Accepts a valid/ready data stream into a 2-entry skid buffer.
- Issues the data to the FIFO as bounded bursts of BURST_LEN words, throttled by full/half_full.
- Inserts a mandatory idle gap between bursts.
- Keeps word and burst counters for the scoreboard and coverage.

Parameters:
DATA_WIDTH, 8, data bus width; must match the FIFO write data width.
DEPTH, 64, FIFO depth; used only for the legality check below.
BURST_LEN, 8, words per burst; legal range 1 <= BURST_LEN <= DEPTH/2.
GAP_CYCLES, 2, idle cycles forced after each burst ends; legal range >= 1.
CNT_W, 16, width of the statistics counters.

Ports:
wr_clk  input  1  write-domain clock
wr_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream data valid
in_data  input  DATA_WIDTH  upstream data
in_ready  output  1  registered; skid buffer can accept a word
burst_abort  input  1  terminate the current burst early
full  input  1  FIFO full (write domain)
half_full  input  1  FIFO at or above DEPTH/2
wr_en  output  1  FIFO write enable
wr_data  output  DATA_WIDTH  FIFO write data
burst_active  output  1  FSM is in BURST
words_written  output  CNT_W  total FIFO writes issued
bursts_done  output  CNT_W  total bursts completed or aborted

Behaviour:
Interface and reset
- One clock (wr_clk). Reset wr_rst_n is asynchronous and active-low.
- While wr_rst_n is low: state=IDLE, buffer empty (buf_cnt=0), in_ready=0, wr_en=0, wr_data=0, burst_active=0, words_written=0, bursts_done=0, beat_cnt=0, gap_cnt=0.
- in_ready rises on the first wr_clk edge after reset deasserts.
- Reset asserted mid-burst: all state is discarded immediately, including any buffered words. No partial write is issued after reset assertion.

Input handshake
- A word is accepted when in_valid && in_ready at a rising edge.
- Skid buffer is a 2-entry in-order queue. Push and pop in the same cycle leave buf_cnt unchanged and preserve order.
- in_ready is registered: in_ready = (next buf_cnt < 2).
- in_data is don't-care when in_valid=0.

FSM (IDLE, BURST, GAP)
- IDLE -> BURST when buf_cnt != 0 && !half_full. beat_cnt is cleared on this transition.
- BURST:
  - wr_en = (buf_cnt != 0) && !full. This is combinational from registered state and full.
  - wr_data = buffer head. wr_data holds its last value when wr_en=0.
  - Each write pops the head, increments beat_cnt and increments words_written.
  - A write with beat_cnt == BURST_LEN-1 -> GAP, and bursts_done increments.
  - An empty buffer or full=1 stalls the burst in BURST with no write. There is no timeout.
  - burst_abort=1 in BURST: wr_en is forced 0 that cycle, the FSM goes to GAP, bursts_done increments, and buffered words are retained.
  - burst_abort is ignored in IDLE and GAP.
- GAP: wr_en=0 for exactly GAP_CYCLES cycles, then -> IDLE.
- burst_active = (state == BURST), registered.
- wr_en is never asserted while full=1 or outside BURST.

Counters and widths
- words_written and bursts_done wrap modulo 2^CNT_W with no saturation.
- beat_cnt width is clog2(BURST_LEN+1).
- BURST_LEN=1: every write ends its burst.

Test Plan:
- Reset, then 8 words 0x10..0x17 back-to-back, full=0, half_full=0 -> after the 1-cycle IDLE->BURST decision, wr_en is high for 8 consecutive cycles with wr_data 0x10..0x17 in order; then 2 GAP cycles; words_written=8, bursts_done=1.
- Stream 20 words continuously with default params -> writes come in three bursts of 8, 8, 4 with 2-cycle gaps between them; the third burst stays in BURST after 4 words (burst_active=1, beat_cnt=4); no data loss or reorder; in_ready drops only when buf_cnt=2.
- full=1 for cycles 3..6 of a burst -> wr_en=0 during those cycles, in_ready goes low once 2 words are buffered, the burst resumes at the same beat_cnt, and the total written is still exactly 8 per burst.
- half_full=1 with words buffered -> FSM stays in IDLE with wr_en=0. half_full drops -> BURST entered on the next edge.
- burst_abort pulsed after beat 3 (words 0xA0..0xA2 written) -> wr_en=0 that cycle, GAP, bursts_done=1. The next burst starts with word 0xA3 and no word is lost.
- wr_rst_n pulsed low mid-burst with 2 words buffered -> all outputs return to reset values immediately; after release, no stale word appears on wr_data with wr_en=1 and counters restart from 0.
